// File: rtl/instmem_resp_pkg.sv
// Shared constants and FSM state encodings for the instruction-memory responder.
package instmem_resp_pkg;

  localparam int ADDR_W_DEF     = 16;
  localparam int DATA_W_DEF     = 32;
  localparam int DEPTH_LOG2_DEF = 8;
  localparam int LATENCY_DEF    = 2;
  localparam int LATENCY_MIN    = 1;
  localparam int LATENCY_MAX    = 15;

  // Wide enough to hold LATENCY_MAX-1
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } estado_e;

endpackage

// File: rtl/instmem_resp_if.sv
// Fetch-side request/response bus plus the preload write port.
interface instmem_resp_if
  import instmem_resp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              MEM_CLK;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] MEM_OUT;
  logic              MEM_RDY;
  logic              BUSY;
  logic              ERR;
  logic              WR_EN;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [DATA_W-1:0] WR_DATA;
  logic [1:0]        ESTADO;

  modport master (
    output MEM_CLK, ADDR, WR_EN, WR_ADDR, WR_DATA,
    input  MEM_OUT, MEM_RDY, BUSY, ERR, ESTADO
  );

  modport slave (
    input  MEM_CLK, ADDR, WR_EN, WR_ADDR, WR_DATA,
    output MEM_OUT, MEM_RDY, BUSY, ERR, ESTADO
  );

endinterface

// File: rtl/instmem_resp_array.sv
// Word array with synchronous write and a registered read port; a read that
// coincides with a write to the same word returns the old contents.
module instmem_array
  import instmem_resp_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_idx,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic                  rd_zero,
  input  logic [DEPTH_LOG2-1:0] rd_idx,
  output logic [DATA_W-1:0]     rd_data
);

  logic [DATA_W-1:0] mem [1 << DEPTH_LOG2];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  // Contents survive reset so a loaded program is not lost
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = rd_zero ? '0 : mem[rd_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/instmem_resp.sv
// Instruction-memory responder: detects MEM_CLK rising samples, waits LATENCY
// cycles, then returns the addressed word with a one-cycle MEM_RDY pulse.
module instmem_resp
  import instmem_resp_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int LATENCY    = LATENCY_DEF
) (
  input logic           CLK,
  input logic           RST,
  instmem_resp_if.slave bus
);

  estado_e           state_q, state_d;
  logic              mem_clk_q, mem_clk_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rdy_q, rdy_d;
  logic              err_q, err_d;
  logic              req;
  logic              rd_en, rd_zero, wr_ok;
  logic [DATA_W-1:0] rd_data;

  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    return (|a[ADDR_W-1:DEPTH_LOG2+2]) || (|a[1:0]);
  endfunction

  assign req   = bus.MEM_CLK & ~mem_clk_q;
  assign wr_ok = bus.WR_EN & ~addr_bad(bus.WR_ADDR);

  always_comb begin
    state_d   = state_q;
    mem_clk_d = bus.MEM_CLK;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    rdy_d     = 1'b0;
    err_d     = err_q;
    rd_en     = 1'b0;
    rd_zero   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = bus.ADDR;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = ST_WAIT;
        end
      end
      // Requests arriving here or in RESP are dropped; BUSY holds fetch off
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rd_en   = 1'b1;
          rd_zero = addr_bad(addr_q);
          if (addr_bad(addr_q)) err_d = 1'b1;
          rdy_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      mem_clk_q <= 1'b0;
      addr_q    <= '0;
      cnt_q     <= '0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_clk_q <= mem_clk_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
    end
  end

  instmem_array #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk    (CLK),
    .rst    (RST),
    .wr_en  (wr_ok),
    .wr_idx (bus.WR_ADDR[DEPTH_LOG2+1:2]),
    .wr_data(bus.WR_DATA),
    .rd_en  (rd_en),
    .rd_zero(rd_zero),
    .rd_idx (addr_q[DEPTH_LOG2+1:2]),
    .rd_data(rd_data)
  );

  assign bus.MEM_OUT = rd_data;
  assign bus.MEM_RDY = rdy_q;
  assign bus.BUSY    = (state_q != ST_IDLE);
  assign bus.ERR     = err_q;
  assign bus.ESTADO  = state_q;

endmodule

// File: tb/tb_instmem_resp.sv
// Directed bench for instmem_resp: per-cycle vector table plus hand-written
// sequences for dropped requests, write/read collision and mid-flight reset.
module tb_instmem_resp;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   rdy_count;

  instmem_resp_if #(.ADDR_W(16), .DATA_W(32)) bus_if ();

  instmem_resp #(
    .ADDR_W    (16),
    .DATA_W    (32),
    .DEPTH_LOG2(8),
    .LATENCY   (2)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus_if)
  );

  typedef struct {
    logic        mc;
    logic [15:0] addr;
    logic [31:0] exp_out;
    logic        exp_rdy;
    logic        exp_busy;
    logic        exp_err;
    logic [1:0]  exp_st;
  } vec_t;

  vec_t vecs[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic mc, input logic [15:0] addr,
                               input logic we, input logic [15:0] wa,
                               input logic [31:0] wd);
    bus_if.MEM_CLK = mc;
    bus_if.ADDR    = addr;
    bus_if.WR_EN   = we;
    bus_if.WR_ADDR = wa;
    bus_if.WR_DATA = wd;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] eo,
                             input logic er, input logic eb, input logic ee,
                             input logic [1:0] es);
    checks += 5;
    if (bus_if.MEM_OUT !== eo) begin
      errors++;
      $display("[TB] FAIL %s MEM_OUT got %h expected %h", name, bus_if.MEM_OUT, eo);
    end
    if (bus_if.MEM_RDY !== er) begin
      errors++;
      $display("[TB] FAIL %s MEM_RDY got %b expected %b", name, bus_if.MEM_RDY, er);
    end
    if (bus_if.BUSY !== eb) begin
      errors++;
      $display("[TB] FAIL %s BUSY got %b expected %b", name, bus_if.BUSY, eb);
    end
    if (bus_if.ERR !== ee) begin
      errors++;
      $display("[TB] FAIL %s ERR got %b expected %b", name, bus_if.ERR, ee);
    end
    if (bus_if.ESTADO !== es) begin
      errors++;
      $display("[TB] FAIL %s ESTADO got %0d expected %0d", name, bus_if.ESTADO, es);
    end
    if (bus_if.MEM_RDY === 1'b1) rdy_count++;
  endtask

  task automatic addVec(input logic mc, input logic [15:0] addr,
                        input logic [31:0] eo, input logic er, input logic eb,
                        input logic ee, input logic [1:0] es);
    vec_t v;
    v.mc = mc; v.addr = addr; v.exp_out = eo; v.exp_rdy = er;
    v.exp_busy = eb; v.exp_err = ee; v.exp_st = es;
    vecs.push_back(v);
  endtask

  task automatic checkCount(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s count got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rdy_count = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 32'h0);

    // Request to word 0, then held-high request to word 1
    addVec(0, 16'h0000, 32'h00000000, 0, 0, 0, 2'd0);
    addVec(1, 16'h0000, 32'h00000000, 0, 1, 0, 2'd1);
    addVec(0, 16'h0000, 32'h00000000, 0, 1, 0, 2'd1);
    addVec(0, 16'h0000, 32'h20010005, 1, 1, 0, 2'd2);
    addVec(0, 16'h0000, 32'h20010005, 0, 0, 0, 2'd0);
    addVec(1, 16'h0004, 32'h20010005, 0, 1, 0, 2'd1);
    addVec(1, 16'h0004, 32'h20010005, 0, 1, 0, 2'd1);
    addVec(1, 16'h0004, 32'h00221820, 1, 1, 0, 2'd2);
    addVec(1, 16'h0004, 32'h00221820, 0, 0, 0, 2'd0);
    addVec(1, 16'h0004, 32'h00221820, 0, 0, 0, 2'd0);
    addVec(1, 16'h0004, 32'h00221820, 0, 0, 0, 2'd0);
    // Out-of-range request sets sticky ERR
    addVec(0, 16'h0400, 32'h00221820, 0, 0, 0, 2'd0);
    addVec(1, 16'h0400, 32'h00221820, 0, 1, 0, 2'd1);
    addVec(0, 16'h0400, 32'h00221820, 0, 1, 0, 2'd1);
    addVec(0, 16'h0400, 32'h00000000, 1, 1, 1, 2'd2);
    addVec(0, 16'h0400, 32'h00000000, 0, 0, 1, 2'd0);
    // Valid request afterwards keeps ERR
    addVec(1, 16'h0000, 32'h00000000, 0, 1, 1, 2'd1);
    addVec(0, 16'h0000, 32'h00000000, 0, 1, 1, 2'd1);
    addVec(0, 16'h0000, 32'h20010005, 1, 1, 1, 2'd2);
    addVec(0, 16'h0000, 32'h20010005, 0, 0, 1, 2'd0);
    // Misaligned request returns zero
    addVec(1, 16'h0002, 32'h20010005, 0, 1, 1, 2'd1);
    addVec(0, 16'h0002, 32'h20010005, 0, 1, 1, 2'd1);
    addVec(0, 16'h0002, 32'h00000000, 1, 1, 1, 2'd2);
    addVec(0, 16'h0002, 32'h00000000, 0, 0, 1, 2'd0);

    step();
    step();
    rst = 1'b0;
    applyStimulus(1'b0, 16'h0, 1'b1, 16'h0000, 32'h20010005);
    step();
    applyStimulus(1'b0, 16'h0, 1'b1, 16'h0004, 32'h00221820);
    step();
    applyStimulus(1'b0, 16'h0, 1'b1, 16'h0008, 32'h11112222);
    step();
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0000, 32'h0);

    rst = 1'b1;
    #1;
    checkOutput("reset", 32'h0, 0, 0, 0, 2'd0);
    step();
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].mc, vecs[i].addr, 1'b0, 16'h0, 32'h0);
      step();
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_rdy,
                  vecs[i].exp_busy, vecs[i].exp_err, vecs[i].exp_st);
    end

    // Clear ERR, then a second edge during WAIT must be dropped
    rst = 1'b1;
    #1;
    checkOutput("err_clear", 32'h0, 0, 0, 0, 2'd0);
    step();
    rst = 1'b0;
    applyStimulus(0, 16'h0004, 0, 16'h0, 32'h0); step();
    checkOutput("drop0", 32'h0, 0, 0, 0, 2'd0);
    rdy_count = 0;
    applyStimulus(1, 16'h0004, 0, 16'h0, 32'h0); step();
    checkOutput("drop1", 32'h0, 0, 1, 0, 2'd1);
    applyStimulus(0, 16'h0004, 0, 16'h0, 32'h0); step();
    checkOutput("drop2", 32'h0, 0, 1, 0, 2'd1);
    applyStimulus(1, 16'h0000, 0, 16'h0, 32'h0); step();
    checkOutput("drop3", 32'h00221820, 1, 1, 0, 2'd2);
    applyStimulus(0, 16'h0000, 0, 16'h0, 32'h0); step();
    checkOutput("drop4", 32'h00221820, 0, 0, 0, 2'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput($sformatf("drop_idle%0d", k), 32'h00221820, 0, 0, 0, 2'd0);
    end
    checkCount("drop_rdy", rdy_count, 1);

    // Write to word 2 on the same edge its read completes
    applyStimulus(1, 16'h0008, 0, 16'h0, 32'h0); step();
    checkOutput("coll1", 32'h00221820, 0, 1, 0, 2'd1);
    applyStimulus(0, 16'h0008, 0, 16'h0, 32'h0); step();
    checkOutput("coll2", 32'h00221820, 0, 1, 0, 2'd1);
    applyStimulus(0, 16'h0008, 1, 16'h0008, 32'hDEADBEEF); step();
    checkOutput("coll3", 32'h11112222, 1, 1, 0, 2'd2);
    applyStimulus(0, 16'h0008, 1, 16'h0408, 32'h0BADF00D); step();
    checkOutput("coll4", 32'h11112222, 0, 0, 0, 2'd0);
    applyStimulus(1, 16'h0008, 1, 16'h000A, 32'h0BADF00D); step();
    checkOutput("coll5", 32'h11112222, 0, 1, 0, 2'd1);
    applyStimulus(0, 16'h0008, 0, 16'h0, 32'h0); step();
    checkOutput("coll6", 32'h11112222, 0, 1, 0, 2'd1);
    step();
    checkOutput("coll7", 32'hDEADBEEF, 1, 1, 0, 2'd2);
    step();
    checkOutput("coll8", 32'hDEADBEEF, 0, 0, 0, 2'd0);

    // Reset while a request is in WAIT
    rdy_count = 0;
    applyStimulus(1, 16'h0000, 0, 16'h0, 32'h0); step();
    checkOutput("rst_mid1", 32'hDEADBEEF, 0, 1, 0, 2'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid2", 32'h0, 0, 0, 0, 2'd0);
    applyStimulus(0, 16'h0000, 0, 16'h0, 32'h0); step();
    checkOutput("rst_mid3", 32'h0, 0, 0, 0, 2'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput($sformatf("rst_idle%0d", k), 32'h0, 0, 0, 0, 2'd0);
    end
    checkCount("rst_rdy", rdy_count, 0);
    applyStimulus(1, 16'h0000, 0, 16'h0, 32'h0); step();
    checkOutput("rst_req1", 32'h0, 0, 1, 0, 2'd1);
    applyStimulus(0, 16'h0000, 0, 16'h0, 32'h0); step();
    checkOutput("rst_req2", 32'h0, 0, 1, 0, 2'd1);
    step();
    checkOutput("rst_req3", 32'h20010005, 1, 1, 0, 2'd2);
    step();
    checkOutput("rst_req4", 32'h20010005, 0, 0, 0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
